// File: rtl/bus_hub_n.sv
`default_nettype none
// ============================================================================
// Module   : bus_hub_n
// Purpose  : Host-to-N-device bus interconnect. Decodes each host request
//            against per-device base/mask pairs, issues a single-cycle
//            strobe to the one selected device and returns a one-cycle
//            completion (with error on unmapped address or device timeout).
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            host_*                   - host request / response side
//            device_address/data/mask - registered, packed N*W device buses
//            device_wen/ren           - one-cycle strobes, selected device
//            device_ready/data_read   - device completion and read data
//            device_active            - one-hot, strobe through completion
// Revision : 1.0 - initial release
// ============================================================================
module bus_hub_n #(
    parameter int                      N_DEVICES  = 4,
    parameter logic [N_DEVICES*32-1:0] BASE_ADDRS = {32'h3000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
    parameter logic [N_DEVICES*32-1:0] ADDR_MASKS = {4{32'hF000_0000}},
    parameter int                      TIMEOUT    = 255,
    parameter logic [31:0]             ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               host_address,
    input  logic [31:0]               host_data_write,
    input  logic [3:0]                host_write_mask,
    input  logic                      host_wen,
    input  logic                      host_ren,
    output logic [31:0]               host_data_read,
    output logic                      host_ready,
    output logic                      host_error,
    output logic [N_DEVICES*32-1:0]   device_address,
    output logic [N_DEVICES*32-1:0]   device_data_write,
    output logic [N_DEVICES*4-1:0]    device_write_mask,
    output logic [N_DEVICES-1:0]      device_ren,
    output logic [N_DEVICES-1:0]      device_wen,
    input  logic [N_DEVICES-1:0]      device_ready,
    input  logic [N_DEVICES*32-1:0]   device_data_read,
    output logic [N_DEVICES-1:0]      device_active
);

    localparam int c_IDX_W = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_sel;
    logic                 r_is_write;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_hit;
    logic [c_IDX_W-1:0]   w_idx;
    logic [N_DEVICES-1:0] w_onehot;
    logic                 w_sel_ready;
    logic [31:0]          w_sel_rdata;
    logic                 w_timed_out;

    // Address decode: scanning from the top down lets the lowest matching
    // index overwrite any higher one, so the lowest index wins on overlap.
    always_comb begin
        w_hit    = 1'b0;
        w_idx    = '0;
        w_onehot = '0;
        for (int i = N_DEVICES - 1; i >= 0; i--) begin
            if ((host_address & ADDR_MASKS[i*32 +: 32]) ==
                (BASE_ADDRS[i*32 +: 32] & ADDR_MASKS[i*32 +: 32])) begin
                w_hit       = 1'b1;
                w_idx       = c_IDX_W'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Only the latched device may complete a transaction; other readies
    // are never looked at.
    assign w_sel_ready = device_ready[r_sel];
    assign w_sel_rdata = device_data_read[{r_sel, 5'd0} +: 32];
    assign w_timed_out = (TIMEOUT != 0) && (r_state == ST_WAIT) && (r_cnt == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_sel             <= '0;
            r_is_write        <= 1'b0;
            r_cnt             <= '0;
            host_data_read    <= '0;
            host_ready        <= 1'b0;
            host_error        <= 1'b0;
            device_address    <= '0;
            device_data_write <= '0;
            device_write_mask <= '0;
            device_ren        <= '0;
            device_wen        <= '0;
            device_active     <= '0;
        end else begin
            // Strobes and the completion pulse last exactly one cycle.
            device_wen <= '0;
            device_ren <= '0;
            host_ready <= 1'b0;
            host_error <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (host_ren || host_wen) begin
                        if (w_hit) begin
                            r_sel      <= w_idx;
                            r_is_write <= host_wen;
                            r_cnt      <= '0;
                            for (int i = 0; i < N_DEVICES; i++) begin
                                device_address[i*32 +: 32] <=
                                    host_address & ~ADDR_MASKS[i*32 +: 32];
                            end
                            device_data_write <= {N_DEVICES{host_data_write}};
                            device_write_mask <= {N_DEVICES{host_write_mask}};
                            // A combined read+write request is a write.
                            device_wen        <= host_wen ? w_onehot : '0;
                            device_ren        <= host_wen ? '0 : w_onehot;
                            device_active     <= w_onehot;
                            r_state           <= ST_STROBE;
                        end else begin
                            host_ready <= 1'b1;
                            host_error <= 1'b1;
                            if (!host_wen) begin
                                host_data_read <= ERR_DATA;
                            end
                            r_state <= ST_RESP;
                        end
                    end
                end

                ST_STROBE, ST_WAIT: begin
                    if (w_sel_ready) begin
                        if (!r_is_write) begin
                            host_data_read <= w_sel_rdata;
                        end
                        host_ready    <= 1'b1;
                        device_active <= '0;
                        r_state       <= ST_RESP;
                    end else if (w_timed_out) begin
                        if (!r_is_write) begin
                            host_data_read <= ERR_DATA;
                        end
                        host_ready    <= 1'b1;
                        host_error    <= 1'b1;
                        device_active <= '0;
                        r_state       <= ST_RESP;
                    end else begin
                        // Counter stays at zero across STROBE so that the
                        // timeout fires after TIMEOUT+1 cycles of WAIT.
                        if (r_state == ST_WAIT && r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_state <= ST_WAIT;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_hub_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_hub_n
// Purpose  : Self-checking bench for bus_hub_n: directed scenarios plus
//            randomized accesses compared against a transaction-level model
//            of decode, latency, error and read-data behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_hub_n;

    localparam int          c_N       = 4;
    localparam int          c_TIMEOUT = 8;
    localparam logic [31:0] c_ERR     = 32'hDEAD_BEEF;
    // Device 3 uses a wider window that overlaps device 2, so 0x2xxx_xxxx
    // exercises the lowest-index-wins rule while 0x3xxx_xxxx reaches device 3.
    localparam logic [c_N*32-1:0] c_BASES = {32'h3000_0000, 32'h2000_0000,
                                             32'h1000_0000, 32'h0000_0000};
    localparam logic [c_N*32-1:0] c_MASKS = {32'hE000_0000, 32'hF000_0000,
                                             32'hF000_0000, 32'hF000_0000};

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          host_address;
    logic [31:0]          host_data_write;
    logic [3:0]           host_write_mask;
    logic                 host_wen;
    logic                 host_ren;
    logic [31:0]          host_data_read;
    logic                 host_ready;
    logic                 host_error;
    logic [c_N*32-1:0]    device_address;
    logic [c_N*32-1:0]    device_data_write;
    logic [c_N*4-1:0]     device_write_mask;
    logic [c_N-1:0]       device_ren;
    logic [c_N-1:0]       device_wen;
    logic [c_N-1:0]       device_ready;
    logic [c_N*32-1:0]    device_data_read;
    logic [c_N-1:0]       device_active;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rd   = 32'h0;

    bus_hub_n #(
        .N_DEVICES  (c_N),
        .BASE_ADDRS (c_BASES),
        .ADDR_MASKS (c_MASKS),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .host_address      (host_address),
        .host_data_write   (host_data_write),
        .host_write_mask   (host_write_mask),
        .host_wen          (host_wen),
        .host_ren          (host_ren),
        .host_data_read    (host_data_read),
        .host_ready        (host_ready),
        .host_error        (host_error),
        .device_address    (device_address),
        .device_data_write (device_data_write),
        .device_write_mask (device_write_mask),
        .device_ren        (device_ren),
        .device_wen        (device_wen),
        .device_ready      (device_ready),
        .device_data_read  (device_data_read),
        .device_active     (device_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // First device whose masked base matches; -1 when unmapped.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < c_N; i++) begin
            if ((a & c_MASKS[i*32 +: 32]) == (c_BASES[i*32 +: 32] & c_MASKS[i*32 +: 32]))
                return i;
        end
        return -1;
    endfunction

    // One host access. lat < 0 means the device never answers.
    // Cycle 1 is the cycle right after the edge that samples the request.
    task automatic access(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] wm, input logic we, input logic re,
                          input int lat, input logic [31:0] rd);
        int          idx;
        logic        hit;
        logic        exp_err;
        int          exp_resp;
        logic [3:0]  onehot;
        logic [3:0]  noise;
        int          cyc;
        int          strobes;
        int          act_cycles;
        logic        done;
        logic [31:0] exp_data;

        idx    = decode(addr);
        hit    = (idx >= 0);
        onehot = hit ? (4'b0001 << idx) : 4'b0000;
        if (!hit) begin
            exp_err  = 1'b1;
            exp_resp = 1;
        end else if (lat < 0) begin
            exp_err  = 1'b1;
            exp_resp = c_TIMEOUT + 3;
        end else begin
            exp_err  = 1'b0;
            exp_resp = 2 + lat;
        end
        if (we)           exp_data = exp_rd;
        else if (exp_err) exp_data = c_ERR;
        else              exp_data = rd;

        host_address    = addr;
        host_data_write = wd;
        host_write_mask = wm;
        host_wen        = we;
        host_ren        = re;
        cyc        = 0;
        strobes    = 0;
        act_cycles = 0;
        done       = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            // Other devices assert ready at random; only the selected one matters.
            noise = 4'($urandom);
            device_data_read = {$urandom, $urandom, $urandom, $urandom};
            if (hit) begin
                noise[idx] = (lat >= 0) && (cyc == 1 + lat);
                device_data_read[idx*32 +: 32] = rd;
            end
            device_ready = noise;

            if ((device_wen != 4'b0) || (device_ren != 4'b0)) begin
                strobes++;
                check("strobe_cycle", 128'(cyc), 128'd1);
                check("dev_wen", device_wen, we ? onehot : 4'b0);
                check("dev_ren", device_ren, we ? 4'b0 : onehot);
                if (hit) begin
                    check("dev_addr", device_address[idx*32 +: 32],
                          addr & ~c_MASKS[idx*32 +: 32]);
                    if (we) begin
                        check("dev_wdata", device_data_write[idx*32 +: 32], wd);
                        check("dev_wmask", device_write_mask[idx*4 +: 4], wm);
                    end
                end
            end
            if (device_active != 4'b0) begin
                act_cycles++;
                check("dev_active", device_active, onehot);
            end
            if (host_ready) begin
                done = 1'b1;
                check("resp_latency", 128'(cyc), 128'(exp_resp));
                check("host_error", host_error, exp_err);
                check("host_rdata", host_data_read, exp_data);
            end
        end
        if (!done) check("resp_never_seen", 128'd0, 128'd1);
        exp_rd = exp_data;
        check("strobe_count", 128'(strobes), hit ? 128'd1 : 128'd0);
        check("active_cycles", 128'(act_cycles), hit ? 128'(exp_resp - 1) : 128'd0);

        host_wen     = 1'b0;
        host_ren     = 1'b0;
        device_ready = 4'b0;
        @(posedge clk);
        #1;
        check("ready_pulse_end", host_ready, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, host_ready, 1'b0);
        check({tag, "_error"}, host_error, 1'b0);
        check({tag, "_rdata"}, host_data_read, 32'h0);
        check({tag, "_strobes"}, {device_wen, device_ren, device_active}, 12'h0);
        check({tag, "_daddr"}, device_address, 128'h0);
        check({tag, "_dwdata"}, device_data_write, 128'h0);
        check({tag, "_dwmask"}, device_write_mask, 16'h0);
    endtask

    initial begin
        rst              = 1'b1;
        host_address     = '0;
        host_data_write  = '0;
        host_write_mask  = '0;
        host_wen         = 1'b0;
        host_ren         = 1'b0;
        device_ready     = '0;
        device_data_read = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst    = 1'b0;
        exp_rd = 32'h0;
        @(posedge clk);
        #1;

        // Directed scenarios.
        access(32'h1000_0040, 32'h0, 4'h0, 1'b0, 1'b1, 1, 32'h1234_5678);
        access(32'h0000_0010, 32'hAABB_CCDD, 4'b0011, 1'b1, 1'b0, 0, 32'h5555_5555);
        access(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b1, 0, 32'h0);
        access(32'h8000_0004, 32'h1111_2222, 4'hF, 1'b1, 1'b0, 0, 32'h0);
        access(32'h2000_0000, 32'h0, 4'h0, 1'b0, 1'b1, -1, 32'h0);
        access(32'h0000_0100, 32'h0, 4'h0, 1'b0, 1'b1, 2, 32'hCAFE_F00D);
        access(32'h2000_0020, 32'h0BAD_0BAD, 4'b1100, 1'b1, 1'b1, 1, 32'h0);
        access(32'h3000_0008, 32'h0, 4'h0, 1'b0, 1'b1, 3, 32'h0123_4567);
        access(32'h2000_0000, 32'h7777_8888, 4'hF, 1'b1, 1'b0, -1, 32'h0);

        // Randomized accesses.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [3:0]  top;
            logic        we;
            logic        re;
            int          lat;
            int          pick;
            pick = int'($urandom_range(0, 5));
            top  = (pick <= 3) ? 4'(pick) : 4'($urandom_range(4, 15));
            a    = {top, 28'($urandom)};
            pick = int'($urandom_range(0, 3));
            we   = (pick == 1) || (pick == 3);
            re   = (pick != 1);
            lat  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            access(a, $urandom, 4'($urandom), we, re, lat, $urandom);
        end

        // Reset while the hub waits on a silent device.
        host_address = 32'h2000_0100;
        host_ren     = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_active", device_active, 4'b0100);
        rst      = 1'b1;
        host_ren = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("midrst");
        device_ready = 4'b0100;
        device_data_read = {4{32'h5A5A_5A5A}};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("midrst_no_ready", {host_ready, device_active}, 5'h0);
        end
        device_ready = 4'b0;
        exp_rd = 32'h0;
        access(32'h0000_0200, 32'h0, 4'h0, 1'b0, 1'b1, 0, 32'h600D_600D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
